fish_sram_arb: RTL and testbench
================================

# fish_sram_arb

Single-port access controller for the initialized fish image SRAM (8-bit data, 16-bit address, one-cycle registered read). It shares the one SRAM port between three requesters: the VGA pixel reader (read), an external write port (e.g., sprite patching), and an internal block-fill engine that clears or paints address ranges. Reads have priority, and a starvation guard guarantees writers progress. It sits between the display pipeline and the SRAM instance, driving the SRAM's `en`/`we`/`addr`/`data_i` directly and consuming its `data_o`.

## Interface
Parameters:
- `DATA_WIDTH`, 8, SRAM word width
- `ADDR_WIDTH`, 16, SRAM address width
- `STARVE_LIMIT`, 4, consecutive cycles a pending write may be refused before it preempts a read (1..15)

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge
- `reset_n`  in  1  synchronous active-low reset
- `rd_req`  in  1  display read request
- `rd_addr`  in  ADDR_WIDTH  read address
- `rd_gnt`  out  1  read accepted this cycle (combinational)
- `rd_data`  out  DATA_WIDTH  read data
- `rd_valid`  out  1  `rd_data` valid (registered)
- `wr_req`  in  1  external write request
- `wr_addr`  in  ADDR_WIDTH  external write address
- `wr_data`  in  DATA_WIDTH  external write data
- `wr_gnt`  out  1  external write performed this cycle (combinational)
- `fill_start`  in  1  start fill; sampled only in IDLE
- `fill_base`  in  ADDR_WIDTH  first fill address
- `fill_len`  in  ADDR_WIDTH+1  number of words, 0..2^ADDR_WIDTH
- `fill_value`  in  DATA_WIDTH  fill word
- `fill_busy`  out  1  fill engine not IDLE
- `fill_done`  out  1  one-cycle pulse when the fill completes
- `sram_en`, `sram_we`  out  1 each  SRAM enable / write enable
- `sram_addr`  out  ADDR_WIDTH  SRAM address
- `sram_wdata`  out  DATA_WIDTH  SRAM write data
- `sram_rdata`  in  DATA_WIDTH  SRAM registered read output

## Operation
- At most one grant per cycle.
- The granted requester's command drives the SRAM in the same cycle: `sram_en`=1, `sram_we`=1 for a write, 0 for a read.
- With no grant, `sram_en`=`sram_we`=0. `sram_addr` and `sram_wdata` are 0.

Arbitration, in priority order:
1. **Starve override.** If `starve_cnt` ≥ `STARVE_LIMIT` and any write source is pending, a write wins over a read.
2. **Read.** Otherwise, if `rd_req` is high, the read wins.
3. **Write round-robin.** Among writes, the pending sources alternate between external and fill, starting with external after reset. A lone pending source always wins.

Starve counter (`starve_cnt`, 4-bit, saturating):
- Increments each cycle that a write is pending and no write is granted.
- Clears on any write grant or when no write is pending.

Fill FSM:
- **IDLE.** When `fill_start`=1 and `fill_len`≠0, latch base, length and value and go to FILL. When `fill_start`=1 and `fill_len`=0, go to DONE.
- **FILL.** The fill write is pending every cycle. Each fill grant writes `fill_value` at the current pointer, increments the pointer modulo 2^ADDR_WIDTH, and decrements the remaining count. The grant that writes the last word moves to DONE.
- **DONE.** `fill_done`=1 for exactly one cycle, then IDLE.
- `fill_busy`=1 in FILL and DONE.
- `fill_start` outside IDLE is ignored.
- While the fill is running, `fill_base`, `fill_len` and `fill_value` may change without effect.

Read return:
- `rd_valid` is the registered copy of `rd_gnt`.
- `rd_data` = `sram_rdata` whenever `rd_valid`=1. Otherwise `rd_data` holds its last value.

Reset (`reset_n`=0 at an edge):
- FSM goes to IDLE; `starve_cnt`=0; round-robin pointer points to external; `rd_valid`=0; `rd_data`=0; `fill_done`=0; `fill_busy`=0.
- Grants and SRAM controls are forced to 0 while `reset_n` is low.
- Reset mid-fill aborts the fill: no `fill_done`, and words already written remain.

## Timing
- Grant and SRAM command occur in the same cycle t as the request.
- Read latency: `rd_valid`/`rd_data` appear in cycle t+1. Back-to-back reads give `rd_valid` every cycle.
- External write completes at the end of the edge of its grant cycle. The requester holds `wr_req`, `wr_addr` and `wr_data` until it sees `wr_gnt`=1.
- A read of an address written in the previous cycle returns the new data.
- A fill of N words with no competing traffic gives `fill_busy` for N+1 cycles, with `fill_done` in the last of them.
- Continuous `rd_req` with a pending write: the write is granted on the (`STARVE_LIMIT`+1)th pending cycle. The read refused that cycle gets no `rd_valid` in the following cycle.

## Test plan
- **Reset behaviour.** Hold `reset_n`=0 for 3 cycles with all requests high → all grants=0, `sram_en`=0, `rd_valid`=0, `fill_busy`=0. Release → reads are granted in the first cycle.
- **Read latency.** Read addresses 0, 1, 2 back-to-back → `rd_valid` high for 3 cycles starting one cycle later, with data equal to the image contents at those addresses.
- **Starvation guard.** `STARVE_LIMIT`=4, `rd_req` held high, `wr_req` to 0x0010 with data 0xA5 → `wr_gnt` in the 5th cycle of the request, then `rd_valid` low for one cycle. Reading 0x0010 returns 0xA5.
- **Fill with wrap.** `fill_base`=0xFFFE, `fill_len`=4, `fill_value`=0x00, no other traffic → writes to 0xFFFE, 0xFFFF, 0x0000, 0x0001; `fill_done` in cycle 5; `fill_busy` high for 5 cycles.
- **Round-robin and restart.** Fill of 6 words with `wr_req` held high → fill and external grants alternate, external first. `fill_start`=1 during the fill is ignored. `fill_len`=0 gives a `fill_done` pulse with no SRAM writes.
- **Reset mid-fill.** Assert reset after 3 words of an 8-word fill → `fill_busy`=0 next cycle, no `fill_done`, only 3 words modified.

Source files
------------

// File: rtl/fish_sram_arb.sv
// Single-port SRAM access controller: display reads, external writes and a block-fill engine.
// Reads have priority; a saturating starve counter lets a pending write preempt a read.
module fish_sram_arb #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_gnt,
  input  logic                  fill_start,
  input  logic [ADDR_WIDTH-1:0] fill_base,
  input  logic [ADDR_WIDTH:0]   fill_len,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  fill_busy,
  output logic                  fill_done,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} fill_state_t;

  fill_state_t           state, state_next;
  logic [ADDR_WIDTH-1:0] fill_ptr;
  logic [ADDR_WIDTH:0]   fill_rem;
  logic [DATA_WIDTH-1:0] fill_val;
  logic [3:0]            starve_cnt;
  logic                  rr_ext;
  logic [DATA_WIDTH-1:0] rd_hold;
  logic                  fill_pend, wr_pend, starve, fill_gnt;

  always_comb begin
    fill_pend = (state == FILL);
    wr_pend   = wr_req | fill_pend;
    starve    = (starve_cnt >= 4'(STARVE_LIMIT)) && wr_pend;
    rd_gnt    = 1'b0;
    wr_gnt    = 1'b0;
    fill_gnt  = 1'b0;
    // Single decision chain guarantees at most one grant; a lone writer ignores the pointer.
    if (reset_n) begin
      if (rd_req && !starve)                     rd_gnt   = 1'b1;
      else if (wr_req && (!fill_pend || rr_ext)) wr_gnt   = 1'b1;
      else if (fill_pend)                        fill_gnt = 1'b1;
    end
    sram_en    = rd_gnt | wr_gnt | fill_gnt;
    sram_we    = wr_gnt | fill_gnt;
    sram_addr  = '0;
    sram_wdata = '0;
    if (rd_gnt) begin
      sram_addr = rd_addr;
    end else if (wr_gnt) begin
      sram_addr  = wr_addr;
      sram_wdata = wr_data;
    end else if (fill_gnt) begin
      sram_addr  = fill_ptr;
      sram_wdata = fill_val;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fill_start) state_next = (fill_len == '0) ? DONE : FILL;
      FILL:    if (fill_gnt && fill_rem == (ADDR_WIDTH+1)'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      fill_ptr   <= '0;
      fill_rem   <= '0;
      fill_val   <= '0;
      starve_cnt <= '0;
      rr_ext     <= 1'b1;
      rd_valid   <= 1'b0;
      rd_hold    <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && fill_start && fill_len != '0) begin
        fill_ptr <= fill_base;
        fill_rem <= fill_len;
        fill_val <= fill_value;
      end else if (fill_gnt) begin
        fill_ptr <= fill_ptr + 1'b1;
        fill_rem <= fill_rem - 1'b1;
      end
      if (wr_gnt || fill_gnt)   starve_cnt <= '0;
      else if (wr_pend)         starve_cnt <= (starve_cnt == '1) ? starve_cnt : starve_cnt + 1'b1;
      else                      starve_cnt <= '0;
      if (wr_gnt)               rr_ext <= 1'b0;
      else if (fill_gnt)        rr_ext <= 1'b1;
      rd_valid <= rd_gnt;
      if (rd_valid)             rd_hold <= sram_rdata;
    end
  end

  assign rd_data   = rd_valid ? sram_rdata : rd_hold;
  assign fill_busy = (state != IDLE);
  assign fill_done = (state == DONE);

endmodule

// File: tb/tb_fish_sram_arb.sv
// Directed bench for fish_sram_arb with a behavioural registered-read SRAM holding a synthetic image.
module tb_fish_sram_arb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rd_req, wr_req, fill_start;
  logic [15:0] rd_addr, wr_addr, fill_base;
  logic [16:0] fill_len;
  logic [7:0]  wr_data, fill_value;
  logic        rd_gnt, rd_valid, wr_gnt, fill_busy, fill_done, sram_en, sram_we;
  logic [7:0]  rd_data, sram_wdata, sram_rdata;
  logic [15:0] sram_addr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fish_sram_arb #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len), .fill_value(fill_value),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  function automatic logic [7:0] img(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // Image SRAM: untouched words read back the initial image.
  bit [7:0] mem   [0:65535];
  bit       wflag [0:65535];
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) begin
        mem[sram_addr]   <= sram_wdata;
        wflag[sram_addr] <= 1'b1;
      end else begin
        sram_rdata <= wflag[sram_addr] ? mem[sram_addr] : img(sram_addr);
      end
    end
  end

  function automatic logic [7:0] peek(input logic [15:0] a);
    return wflag[a] ? mem[a] : img(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    reset_n = 1'b1; rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    fill_start = 1'b0; fill_base = '0; fill_len = '0; fill_value = '0;
  endtask

  typedef struct {
    logic        rst_n, rd, wr;
    logic [15:0] ra, wa;
    logic [7:0]  wd;
    logic        g_rd, g_wr, e_en, e_we, e_rv;
    logic [15:0] e_addr;
    logic [7:0]  e_wdata, e_rdata;
  } vec_t;

  function automatic vec_t mk(input logic rst, rd, input logic [15:0] ra, input logic wr,
                              input logic [15:0] wa, input logic [7:0] wd, input logic g_rd, g_wr,
                              input logic [15:0] ea, input logic [7:0] ewd, input logic rv,
                              input logic [7:0] rdat);
    vec_t v;
    v.rst_n = rst; v.rd = rd; v.ra = ra; v.wr = wr; v.wa = wa; v.wd = wd;
    v.g_rd = g_rd; v.g_wr = g_wr; v.e_en = g_rd | g_wr; v.e_we = g_wr;
    v.e_addr = ea; v.e_wdata = ewd; v.e_rv = rv; v.e_rdata = rdat;
    return v;
  endfunction

  vec_t vecs [17];

  initial begin
    logic [15:0] ea;
    int ext_k, fill_k;
    logic exp_ext, exp_fill;

    // Reset, read latency/hold, starvation override, read-after-write, lone external write.
    vecs[0]  = mk(0, 1, 16'h0005, 1, 16'h0010, 8'hA5, 0, 0, 16'h0000, 8'h00, 0, 8'h00);
    vecs[1]  = vecs[0];
    vecs[2]  = vecs[0];
    vecs[3]  = mk(1, 1, 16'h0000, 0, 16'h0000, 8'h00, 1, 0, 16'h0000, 8'h00, 0, 8'h00);
    vecs[4]  = mk(1, 1, 16'h0001, 0, 16'h0000, 8'h00, 1, 0, 16'h0001, 8'h00, 1, img(16'h0000));
    vecs[5]  = mk(1, 1, 16'h0002, 0, 16'h0000, 8'h00, 1, 0, 16'h0002, 8'h00, 1, img(16'h0001));
    vecs[6]  = mk(1, 0, 16'h0000, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 1, img(16'h0002));
    vecs[7]  = mk(1, 0, 16'h0000, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 0, img(16'h0002));
    vecs[8]  = mk(1, 1, 16'h0003, 1, 16'h0010, 8'hA5, 1, 0, 16'h0003, 8'h00, 0, img(16'h0002));
    vecs[9]  = mk(1, 1, 16'h0004, 1, 16'h0010, 8'hA5, 1, 0, 16'h0004, 8'h00, 1, img(16'h0003));
    vecs[10] = mk(1, 1, 16'h0005, 1, 16'h0010, 8'hA5, 1, 0, 16'h0005, 8'h00, 1, img(16'h0004));
    vecs[11] = mk(1, 1, 16'h0006, 1, 16'h0010, 8'hA5, 1, 0, 16'h0006, 8'h00, 1, img(16'h0005));
    vecs[12] = mk(1, 1, 16'h0007, 1, 16'h0010, 8'hA5, 0, 1, 16'h0010, 8'hA5, 1, img(16'h0006));
    vecs[13] = mk(1, 1, 16'h0010, 0, 16'h0000, 8'h00, 1, 0, 16'h0010, 8'h00, 0, img(16'h0006));
    vecs[14] = mk(1, 0, 16'h0000, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 1, 8'hA5);
    vecs[15] = mk(1, 0, 16'h0000, 1, 16'h0020, 8'h3C, 0, 1, 16'h0020, 8'h3C, 0, 8'hA5);
    vecs[16] = mk(1, 0, 16'h0000, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 8'hA5);

    set_idle();
    reset_n = 1'b0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      set_idle();
      reset_n = vecs[i].rst_n; rd_req = vecs[i].rd; rd_addr = vecs[i].ra;
      wr_req = vecs[i].wr; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      #1;
      chk($sformatf("row%0d rd_gnt", i),     32'(rd_gnt),     32'(vecs[i].g_rd));
      chk($sformatf("row%0d wr_gnt", i),     32'(wr_gnt),     32'(vecs[i].g_wr));
      chk($sformatf("row%0d sram_en", i),    32'(sram_en),    32'(vecs[i].e_en));
      chk($sformatf("row%0d sram_we", i),    32'(sram_we),    32'(vecs[i].e_we));
      chk($sformatf("row%0d sram_addr", i),  32'(sram_addr),  32'(vecs[i].e_addr));
      chk($sformatf("row%0d sram_wdata", i), 32'(sram_wdata), 32'(vecs[i].e_wdata));
      chk($sformatf("row%0d rd_valid", i),   32'(rd_valid),   32'(vecs[i].e_rv));
      chk($sformatf("row%0d rd_data", i),    32'(rd_data),    32'(vecs[i].e_rdata));
      if (i < 3) chk($sformatf("row%0d fill_busy", i), 32'(fill_busy), 32'd0);
    end

    // Fill with address wrap; fill inputs change mid-fill without effect.
    @(negedge clk);
    set_idle();
    fill_start = 1'b1; fill_base = 16'hFFFE; fill_len = 17'd4; fill_value = 8'h00;
    #1;
    chk("wrap c0 busy", 32'(fill_busy), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      set_idle();
      fill_base = 16'h1234; fill_len = 17'd7; fill_value = 8'hFF;
      #1;
      ea = 16'hFFFE + 16'(k - 1);
      chk($sformatf("wrap c%0d busy", k),  32'(fill_busy),  32'd1);
      chk($sformatf("wrap c%0d done", k),  32'(fill_done),  32'd0);
      chk($sformatf("wrap c%0d en", k),    32'(sram_en),    32'd1);
      chk($sformatf("wrap c%0d we", k),    32'(sram_we),    32'd1);
      chk($sformatf("wrap c%0d addr", k),  32'(sram_addr),  32'(ea));
      chk($sformatf("wrap c%0d wdata", k), 32'(sram_wdata), 32'h00);
    end
    @(negedge clk); set_idle(); #1;
    chk("wrap c5 done", 32'(fill_done), 32'd1);
    chk("wrap c5 busy", 32'(fill_busy), 32'd1);
    chk("wrap c5 en",   32'(sram_en),   32'd0);
    @(negedge clk); #1;
    chk("wrap c6 done", 32'(fill_done), 32'd0);
    chk("wrap c6 busy", 32'(fill_busy), 32'd0);
    chk("wrap mem FFFD", 32'(peek(16'hFFFD)), 32'(img(16'hFFFD)));
    chk("wrap mem FFFE", 32'(peek(16'hFFFE)), 32'h00);
    chk("wrap mem FFFF", 32'(peek(16'hFFFF)), 32'h00);
    chk("wrap mem 0000", 32'(peek(16'h0000)), 32'h00);
    chk("wrap mem 0001", 32'(peek(16'h0001)), 32'h00);
    chk("wrap mem 0002", 32'(peek(16'h0002)), 32'(img(16'h0002)));

    // Round robin between external writer and a 6-word fill, with an ignored restart.
    @(negedge clk); set_idle(); reset_n = 1'b0;
    ext_k = 0; fill_k = 0;
    for (int c = 0; c <= 14; c++) begin
      @(negedge clk);
      set_idle();
      wr_req  = (c <= 13);
      wr_addr = 16'h0200 + 16'(ext_k);
      wr_data = 8'h11 + 8'(ext_k);
      if (c == 0) begin
        fill_start = 1'b1; fill_base = 16'h0100; fill_len = 17'd6; fill_value = 8'h77;
      end
      if (c == 5) begin
        fill_start = 1'b1; fill_base = 16'h0500; fill_len = 17'd2; fill_value = 8'h99;
      end
      #1;
      exp_ext  = (c == 0) || (c == 12) || (c == 13) || (c >= 2 && c <= 10 && c % 2 == 0);
      exp_fill = (c >= 1 && c <= 11 && c % 2 == 1);
      ea = exp_ext ? 16'h0200 + 16'(ext_k) : (exp_fill ? 16'h0100 + 16'(fill_k) : 16'h0000);
      chk($sformatf("rr c%0d wr_gnt", c), 32'(wr_gnt),    32'(exp_ext));
      chk($sformatf("rr c%0d en", c),     32'(sram_en),   32'(exp_ext | exp_fill));
      chk($sformatf("rr c%0d we", c),     32'(sram_we),   32'(exp_ext | exp_fill));
      chk($sformatf("rr c%0d addr", c),   32'(sram_addr), 32'(ea));
      chk($sformatf("rr c%0d wdata", c),  32'(sram_wdata),
          exp_ext ? 32'(8'h11 + 8'(ext_k)) : (exp_fill ? 32'h77 : 32'h00));
      chk($sformatf("rr c%0d done", c),   32'(fill_done), 32'(c == 12));
      chk($sformatf("rr c%0d busy", c),   32'(fill_busy), 32'(c >= 1 && c <= 12));
      if (exp_ext)  ext_k++;
      if (exp_fill) fill_k++;
    end
    chk("rr mem 0100", 32'(peek(16'h0100)), 32'h77);
    chk("rr mem 0105", 32'(peek(16'h0105)), 32'h77);
    chk("rr mem 0106", 32'(peek(16'h0106)), 32'(img(16'h0106)));
    chk("rr mem 0207", 32'(peek(16'h0207)), 32'h18);
    chk("rr mem 0500", 32'(peek(16'h0500)), 32'(img(16'h0500)));

    // Zero-length fill: done pulse, no SRAM activity.
    @(negedge clk); set_idle(); fill_start = 1'b1; fill_base = 16'h0600; fill_len = 17'd0;
    fill_value = 8'h55; #1;
    chk("zero c0 en",   32'(sram_en),   32'd0);
    chk("zero c0 busy", 32'(fill_busy), 32'd0);
    @(negedge clk); set_idle(); #1;
    chk("zero c1 done", 32'(fill_done), 32'd1);
    chk("zero c1 busy", 32'(fill_busy), 32'd1);
    chk("zero c1 en",   32'(sram_en),   32'd0);
    @(negedge clk); #1;
    chk("zero c2 done", 32'(fill_done), 32'd0);
    chk("zero c2 busy", 32'(fill_busy), 32'd0);
    chk("zero mem 0600", 32'(peek(16'h0600)), 32'(img(16'h0600)));

    // Reset after three words of an eight-word fill aborts it.
    @(negedge clk); set_idle(); fill_start = 1'b1; fill_base = 16'h0300; fill_len = 17'd8;
    fill_value = 8'hEE;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); set_idle(); #1;
      chk($sformatf("abort c%0d addr", k), 32'(sram_addr), 32'(16'h0300 + 16'(k - 1)));
      chk($sformatf("abort c%0d we", k),   32'(sram_we),   32'd1);
    end
    @(negedge clk); set_idle(); reset_n = 1'b0; wr_req = 1'b1; rd_req = 1'b1; #1;
    chk("abort c4 en",     32'(sram_en), 32'd0);
    chk("abort c4 rd_gnt", 32'(rd_gnt),  32'd0);
    chk("abort c4 wr_gnt", 32'(wr_gnt),  32'd0);
    @(negedge clk); set_idle(); #1;
    chk("abort c5 busy", 32'(fill_busy), 32'd0);
    chk("abort c5 done", 32'(fill_done), 32'd0);
    chk("abort c5 en",   32'(sram_en),   32'd0);
    @(negedge clk); #1;
    chk("abort c6 done", 32'(fill_done), 32'd0);
    chk("abort mem 0302", 32'(peek(16'h0302)), 32'hEE);
    chk("abort mem 0303", 32'(peek(16'h0303)), 32'(img(16'h0303)));
    chk("abort mem 0307", 32'(peek(16'h0307)), 32'(img(16'h0307)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
